// File: rtl/tensor_core_controller.sv
// Single-cycle instruction-driven controller for a 3x3 int8 tensor core.
// Each 16-bit instruction is applied in one clock; matrices A and B live in the register file.

module tensor_core_register_file #(
    parameter int BUS_WIDTH = 7
) (
    input  logic                        clock_in,
    input  logic                        reset_in,
    input  logic signed [BUS_WIDTH:0]   next_registers [0:1][0:2][0:2],
    output logic signed [BUS_WIDTH:0]   registers      [0:1][0:2][0:2]
);

    always_ff @(posedge clock_in) begin
        for (int unsigned m = 0; m < 2; m++) begin
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    if (!reset_in) begin
                        registers[m][r][c] <= '0;
                    end else begin
                        registers[m][r][c] <= next_registers[m][r][c];
                    end
                end
            end
        end
    end

endmodule

module tensor_core_controller #(
    parameter int BUS_WIDTH = 7
) (
    input  logic                        clock_in,
    input  logic                        reset_in,
    input  logic [15:0]                 current_instruction,
    output logic signed [BUS_WIDTH:0]   tensor_core_controller_output
);

    localparam int ELEM_W = BUS_WIDTH + 1;
    localparam int ACC_W  = 2 * ELEM_W + 2;

    typedef enum logic [2:0] {
        OP_NOP    = 3'b000,
        OP_WRITE  = 3'b001,
        OP_READ   = 3'b010,
        OP_MATMUL = 3'b011,
        OP_MATADD = 3'b100,
        OP_CLEAR  = 3'b101,
        OP_MOVE   = 3'b110,
        OP_RSVD   = 3'b111
    } opcode_t;

    opcode_t                  opcode;
    logic [7:0]               imm8;
    int unsigned              src_index;
    int unsigned              dst_index;

    logic signed [BUS_WIDTH:0] regs      [0:1][0:2][0:2];
    logic signed [BUS_WIDTH:0] next_regs [0:1][0:2][0:2];
    logic signed [BUS_WIDTH:0] src_value;
    logic signed [BUS_WIDTH:0] output_next;
    logic signed [ACC_W-1:0]   acc;

    assign opcode    = opcode_t'(current_instruction[15:13]);
    assign imm8      = current_instruction[7:0];
    assign src_index = 32'(current_instruction[12:8]);
    assign dst_index = 32'(current_instruction[4:0]);

    function automatic int unsigned flat_index(int unsigned m, int unsigned r, int unsigned c);
        return m * 9 + r * 3 + c;
    endfunction

    tensor_core_register_file #(
        .BUS_WIDTH(BUS_WIDTH)
    ) main_tensor_core_register_file (
        .clock_in       (clock_in),
        .reset_in       (reset_in),
        .next_registers (next_regs),
        .registers      (regs)
    );

    // Out-of-range source indices never match, so they read as zero.
    always_comb begin
        src_value = '0;
        for (int unsigned m = 0; m < 2; m++)
            for (int unsigned r = 0; r < 3; r++)
                for (int unsigned c = 0; c < 3; c++)
                    if (flat_index(m, r, c) == src_index)
                        src_value = regs[m][r][c];
    end

    always_comb begin
        next_regs   = regs;
        output_next = tensor_core_controller_output;
        acc         = '0;
        case (opcode)
            OP_WRITE: begin
                for (int unsigned m = 0; m < 2; m++)
                    for (int unsigned r = 0; r < 3; r++)
                        for (int unsigned c = 0; c < 3; c++)
                            if (flat_index(m, r, c) == src_index)
                                next_regs[m][r][c] = ELEM_W'(imm8);
            end
            OP_READ: begin
                output_next = src_value;
            end
            OP_MATMUL: begin
                // All sums read the registered A, so the update is simultaneous.
                for (int unsigned r = 0; r < 3; r++) begin
                    for (int unsigned c = 0; c < 3; c++) begin
                        acc = '0;
                        for (int unsigned k = 0; k < 3; k++)
                            acc = acc + ACC_W'(regs[0][r][k]) * ACC_W'(regs[1][k][c]);
                        next_regs[0][r][c] = acc[BUS_WIDTH:0];
                    end
                end
            end
            OP_MATADD: begin
                for (int unsigned r = 0; r < 3; r++)
                    for (int unsigned c = 0; c < 3; c++)
                        next_regs[0][r][c] = regs[0][r][c] + regs[1][r][c];
            end
            OP_CLEAR: begin
                for (int unsigned m = 0; m < 2; m++)
                    for (int unsigned r = 0; r < 3; r++)
                        for (int unsigned c = 0; c < 3; c++)
                            next_regs[m][r][c] = '0;
            end
            OP_MOVE: begin
                for (int unsigned m = 0; m < 2; m++)
                    for (int unsigned r = 0; r < 3; r++)
                        for (int unsigned c = 0; c < 3; c++)
                            if (flat_index(m, r, c) == dst_index)
                                next_regs[m][r][c] = src_value;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            tensor_core_controller_output <= '0;
        end else begin
            tensor_core_controller_output <= output_next;
        end
    end

endmodule

// File: tb/tb_tensor_core_controller.sv
// Directed plus randomized bench for tensor_core_controller against a flat-array model.
module tb_tensor_core_controller;

    logic              clock_in;
    logic              reset_in;
    logic [15:0]       current_instruction;
    logic signed [7:0] tensor_core_controller_output;

    int compared;
    int mismatched;

    logic signed [7:0] mdl [18];
    logic signed [7:0] mdl_out;

    tensor_core_controller #(
        .BUS_WIDTH(7)
    ) dut (
        .clock_in                      (clock_in),
        .reset_in                      (reset_in),
        .current_instruction           (current_instruction),
        .tensor_core_controller_output (tensor_core_controller_output)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic signed [7:0] obs, input logic signed [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [7:0] probe(input int e);
        return dut.main_tensor_core_register_file.registers[e / 9][(e % 9) / 3][e % 3];
    endfunction

    task automatic check_all(input string tag);
        for (int e = 0; e < 18; e++)
            check($sformatf("%s_e%0d", tag, e), probe(e), mdl[e]);
        check($sformatf("%s_out", tag), tensor_core_controller_output, mdl_out);
    endtask

    // Reference: flat elements 0..8 are A row-major, 9..17 are B row-major.
    task automatic model_step(input logic rst_n, input logic [15:0] ins);
        int op, idx, dst, s;
        logic signed [7:0] src;
        logic signed [7:0] tmp [9];
        if (!rst_n) begin
            for (int i = 0; i < 18; i++) mdl[i] = 0;
            mdl_out = 0;
            return;
        end
        op  = int'(ins[15:13]);
        idx = int'(ins[12:8]);
        dst = int'(ins[4:0]);
        src = (idx < 18) ? mdl[idx] : 8'sd0;
        case (op)
            1: if (idx < 18) mdl[idx] = ins[7:0];
            2: mdl_out = src;
            3: begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) begin
                        s = 0;
                        for (int k = 0; k < 3; k++)
                            s += int'(mdl[r * 3 + k]) * int'(mdl[9 + k * 3 + c]);
                        tmp[r * 3 + c] = s[7:0];
                    end
                for (int i = 0; i < 9; i++) mdl[i] = tmp[i];
            end
            4: for (int i = 0; i < 9; i++) begin
                s = int'(mdl[i]) + int'(mdl[9 + i]);
                mdl[i] = s[7:0];
            end
            5: for (int i = 0; i < 18; i++) mdl[i] = 0;
            6: if (dst < 18) mdl[dst] = src;
            default: ;
        endcase
    endtask

    task automatic exec(input logic rst_n, input logic [15:0] ins, input string tag);
        @(negedge clock_in);
        reset_in = rst_n;
        current_instruction = ins;
        @(posedge clock_in);
        model_step(rst_n, ins);
        #1;
        check_all(tag);
    endtask

    task automatic wr(input int e, input int v);
        logic [4:0] ei;
        logic [7:0] vi;
        ei = 5'(e);
        vi = 8'(v);
        exec(1'b1, {3'b001, ei, vi}, "write");
    endtask

    task automatic load_mats(input int a [9], input int b [9]);
        for (int i = 0; i < 9; i++) wr(i, a[i]);
        for (int i = 0; i < 9; i++) wr(9 + i, b[i]);
    endtask

    initial begin
        int a [9];
        int b [9];
        logic [15:0] ins;
        compared   = 0;
        mismatched = 0;
        mdl_out    = 0;
        for (int i = 0; i < 18; i++) mdl[i] = 0;
        reset_in = 1'b0;
        current_instruction = 16'h2105;

        // Reset held for two edges with WRITE applied.
        @(posedge clock_in);
        @(negedge clock_in);
        exec(1'b0, 16'h2105, "reset");
        for (int e = 0; e < 18; e++) check("reset_zero", probe(e), 8'sd0);
        check("reset_out_zero", tensor_core_controller_output, 8'sd0);

        exec(1'b1, 16'h2105, "wr_e1");
        exec(1'b1, 16'h2E80, "wr_e14");
        exec(1'b1, 16'h3E80, "wr_idx30");
        exec(1'b1, 16'h4100, "rd_e1");
        check("read_e1_is_5", tensor_core_controller_output, 8'sd5);
        exec(1'b1, 16'h4E00, "rd_e14");
        check("read_e14_is_m128", tensor_core_controller_output, -8'sd128);
        exec(1'b1, 16'h0000, "nop_hold");
        check("nop_holds_m128", tensor_core_controller_output, -8'sd128);

        a = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        b = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        load_mats(a, b);
        exec(1'b1, 16'h6000, "mm_ident");
        for (int i = 0; i < 9; i++) check("mm_ident_A", probe(i), 8'(a[i]));
        for (int i = 0; i < 9; i++) check("mm_ident_B", probe(9 + i), 8'(b[i]));

        a = '{default: 1};
        b = '{default: 2};
        load_mats(a, b);
        exec(1'b1, 16'h6000, "mm_ones");
        for (int i = 0; i < 9; i++) check("mm_ones_6", probe(i), 8'sd6);

        a = '{default: 10};
        b = '{default: 10};
        load_mats(a, b);
        exec(1'b1, 16'h6000, "mm_wrap");
        for (int i = 0; i < 9; i++) check("mm_wrap_44", probe(i), 8'sd44);

        a = '{default: 100};
        b = '{default: 100};
        load_mats(a, b);
        exec(1'b1, 16'h8000, "madd_wrap");
        for (int i = 0; i < 9; i++) check("madd_m56", probe(i), -8'sd56);
        for (int i = 0; i < 9; i++) check("madd_B100", probe(9 + i), 8'sd100);

        wr(3, 7);
        exec(1'b1, 16'hC30C, "move_3_12");
        check("move_dst", dut.main_tensor_core_register_file.registers[1][1][0], 8'sd7);
        exec(1'b1, 16'hC505, "move_self");
        exec(1'b1, 16'hDF02, "move_badsrc");
        check("move_badsrc_zero", probe(2), 8'sd0);
        exec(1'b1, 16'hC114, "move_baddst");
        exec(1'b1, 16'h4300, "rd_e3");
        exec(1'b1, 16'hA000, "clear");
        for (int e = 0; e < 18; e++) check("clear_zero", probe(e), 8'sd0);
        check("clear_out_held", tensor_core_controller_output, 8'sd7);

        exec(1'b1, 16'h3455, "wr_idx20");
        exec(1'b1, 16'h5F00, "rd_idx31");
        check("read31_zero", tensor_core_controller_output, 8'sd0);

        // Randomized traffic, mostly in-range indices, with occasional resets.
        for (int n = 0; n < 400; n++) begin
            ins[15:13] = 3'($urandom_range(0, 7));
            ins[12:8]  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 17));
            ins[7:0]   = 8'($urandom);
            if (ins[15:13] == 3'b110 && $urandom_range(0, 3) != 0)
                ins[4:0] = 5'($urandom_range(0, 17));
            if (ins[15:13] == 3'b101 && $urandom_range(0, 3) != 0)
                ins[15:13] = 3'b001;
            exec(($urandom_range(0, 60) != 0), ins, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
